simon_data_in: RTL and testbench

- Input-side packet unpacker for the SIMON core: the receive-direction counterpart of the output packer.
- Accepts one (N/2+2)-byte input packet from the host-side interface over a 4-phase handshake.
- Validates the header, then delivers key words or one or two plaintext/ciphertext blocks to the core over a valid/ready-style handshake.
- Tracks the input packet sequence count.

---
 rtl/simon_data_in_pkg.sv | 22 ++
 rtl/simon_pkt_check.sv | 18 +
 rtl/simon_data_in.sv | 121 ++++++++++++
 tb/tb_simon_data_in.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/simon_data_in_pkg.sv
// rtl/simon_data_in_pkg.sv - shared constants and state type for the SIMON input unpacker
package simon_data_in_pkg;
    localparam int N_DEF = 16;
    localparam logic [3:0] MODE_DEF = 4'h2;

    localparam int INFO_DIR = 4;
    localparam int INFO_KEY = 5;
    localparam int INFO_TWO = 7;

    function automatic int pkt_bytes(input int n);
        return n / 2 + 2;
    endfunction

    typedef enum logic [2:0] {
        S_WAIT,
        S_LOAD,
        S_KEY,
        S_SEND0,
        S_SEND1,
        S_ACK
    } state_t;
endpackage

// File: rtl/simon_pkt_check.sv
// rtl/simon_pkt_check.sv - combinational header validation for an input packet
module simon_pkt_check
    import simon_data_in_pkg::*;
#(
    parameter logic [3:0] MODE = MODE_DEF
) (
    input  logic [7:0] info,
    input  logic [7:0] count,
    input  logic [7:0] expected,
    output logic       ok,
    output logic [2:0] reason
);
    // reason: [0] sequence count, [1] mode nibble, [2] wrong direction
    assign reason[0] = (count != expected);
    assign reason[1] = (info[3:0] != MODE);
    assign reason[2] = info[INFO_DIR];
    assign ok        = ~|reason;
endmodule

// File: rtl/simon_data_in.sv
// rtl/simon_data_in.sv - input packet unpacker delivering key words or data blocks to the SIMON core
module simon_data_in
    import simon_data_in_pkg::*;
#(
    parameter int         N    = N_DEF,
    parameter logic [3:0] MODE = MODE_DEF
) (
    input  logic                          clk,
    input  logic                          nR,
    input  logic [pkt_bytes(N)*8-1:0]     in,
    input  logic                          donePKT,
    output logic                          readPKT,
    output logic [2*N-1:0]                inDATA,
    output logic [7:0]                    infoIN,
    output logic [7:0]                    countIN,
    output logic                          doneDATA,
    input  logic                          readDATA,
    output logic [4*N-1:0]                key,
    output logic                          loadKEY,
    output logic                          errPKT
);
    state_t         state;
    logic [7:0]     info_q;
    logic [7:0]     count_q;
    logic [4*N-1:0] data_q;
    logic [7:0]     exp_cnt;
    logic           hdr_ok;
    logic [2:0]     hdr_reason;

    simon_pkt_check #(.MODE(MODE)) u_check (
        .info     (info_q),
        .count    (count_q),
        .expected (exp_cnt),
        .ok       (hdr_ok),
        .reason   (hdr_reason)
    );

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state    <= S_WAIT;
            info_q   <= '0;
            count_q  <= '0;
            data_q   <= '0;
            exp_cnt  <= '0;
            readPKT  <= 1'b0;
            inDATA   <= '0;
            infoIN   <= '0;
            countIN  <= '0;
            doneDATA <= 1'b0;
            key      <= '0;
            loadKEY  <= 1'b0;
            errPKT   <= 1'b0;
        end else begin
            loadKEY <= 1'b0;
            errPKT  <= 1'b0;
            case (state)
                S_WAIT: begin
                    readPKT <= 1'b0;
                    if (donePKT) begin
                        {info_q, count_q, data_q} <= in;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!hdr_ok) begin
                        errPKT  <= 1'b1;
                        readPKT <= 1'b1;
                        state   <= S_ACK;
                    end else begin
                        exp_cnt <= exp_cnt + 8'd1;
                        infoIN  <= info_q;
                        countIN <= count_q;
                        // Outputs are set on entry so they are valid in the first cycle of the next state
                        if (info_q[INFO_KEY]) begin
                            key     <= data_q;
                            loadKEY <= 1'b1;
                            state   <= S_KEY;
                        end else begin
                            inDATA   <= data_q[2*N-1:0];
                            doneDATA <= 1'b1;
                            state    <= S_SEND0;
                        end
                    end
                end
                S_KEY: begin
                    readPKT <= 1'b1;
                    state   <= S_ACK;
                end
                S_SEND0: begin
                    if (readDATA) begin
                        doneDATA <= 1'b0;
                        if (info_q[INFO_TWO]) begin
                            state <= S_SEND1;
                        end else begin
                            readPKT <= 1'b1;
                            state   <= S_ACK;
                        end
                    end
                end
                S_SEND1: begin
                    // First cycle here is the mandatory low gap between the two blocks
                    if (!doneDATA) begin
                        inDATA   <= data_q[4*N-1:2*N];
                        doneDATA <= 1'b1;
                    end else if (readDATA) begin
                        doneDATA <= 1'b0;
                        readPKT  <= 1'b1;
                        state    <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!donePKT) begin
                        readPKT <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_simon_data_in.sv
// tb/tb_simon_data_in.sv - self-checking bench for simon_data_in
module tb_simon_data_in;
    logic        clk = 1'b0;
    logic        nR = 1'b0;
    logic [79:0] in_bus = '0;
    logic        donePKT = 1'b0;
    logic        readDATA = 1'b0;
    logic        readPKT;
    logic [31:0] inDATA;
    logic [7:0]  infoIN;
    logic [7:0]  countIN;
    logic        doneDATA;
    logic [63:0] key;
    logic        loadKEY;
    logic        errPKT;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural expectations, updated by the driver from the packet-level rules
    logic [7:0]  m_cnt = 8'd0;
    logic        e_done = 1'b0, e_rpkt = 1'b0, e_err = 1'b0, e_load = 1'b0;
    logic [31:0] e_data = '0;
    logic [63:0] e_key = '0;
    logic [7:0]  e_info = '0, e_count = '0;

    simon_data_in #(.N(16), .MODE(4'h2)) dut (
        .clk      (clk),
        .nR       (nR),
        .in       (in_bus),
        .donePKT  (donePKT),
        .readPKT  (readPKT),
        .inDATA   (inDATA),
        .infoIN   (infoIN),
        .countIN  (countIN),
        .doneDATA (doneDATA),
        .readDATA (readDATA),
        .key      (key),
        .loadKEY  (loadKEY),
        .errPKT   (errPKT)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("doneDATA", 64'(doneDATA), 64'(e_done));
            cmp("readPKT",  64'(readPKT),  64'(e_rpkt));
            cmp("errPKT",   64'(errPKT),   64'(e_err));
            cmp("loadKEY",  64'(loadKEY),  64'(e_load));
            cmp("inDATA",   64'(inDATA),   64'(e_data));
            cmp("key",      key,           e_key);
            cmp("infoIN",   64'(infoIN),   64'(e_info));
            cmp("countIN",  64'(countIN),  64'(e_count));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] info, input logic [7:0] cnt,
                            input logic [63:0] data, input int stall, input logic rd_idle);
        logic acc;
        logic two;
        acc = (cnt == m_cnt) && (info[3:0] == 4'h2) && !info[4];
        two = info[7] && !info[5];
        in_bus   = {info, cnt, data};
        donePKT  = 1'b1;
        readDATA = rd_idle;
        step();                 // capture; LOAD cycle changes nothing visible
        step();                 // header decision
        if (!acc) begin
            e_err  = 1'b1;
            e_rpkt = 1'b1;
            step();
            e_err  = 1'b0;
        end else if (info[5]) begin
            m_cnt   = m_cnt + 8'd1;
            e_info  = info;
            e_count = cnt;
            e_load  = 1'b1;
            e_key   = data;
            step();
            e_load  = 1'b0;
            e_rpkt  = 1'b1;
        end else begin
            m_cnt    = m_cnt + 8'd1;
            e_info   = info;
            e_count  = cnt;
            e_done   = 1'b1;
            e_data   = data[31:0];
            readDATA = 1'b0;
            repeat (stall) step();
            readDATA = 1'b1;
            step();
            e_done   = 1'b0;
            if (stall != 0 || !two) readDATA = 1'b0;
            if (two) begin
                step();         // gap cycle; a held readDATA must be ignored here
                e_done = 1'b1;
                e_data = data[63:32];
                repeat (stall) step();
                readDATA = 1'b1;
                step();
                readDATA = 1'b0;
                e_done   = 1'b0;
            end
            e_rpkt = 1'b1;
        end
        step();
        donePKT  = 1'b0;
        readDATA = 1'b0;
        step();
        e_rpkt = 1'b0;
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        step();
        nR = 1'b1;
        step();

        // 1: single block, readDATA high during LOAD is ignored
        send_pkt(8'h02, 8'd0, 64'h0000_0000_6565_6877, 0, 1'b1);
        cmp("t1_inDATA", 64'(inDATA), 64'h6565_6877);
        cmp("t1_countIN", 64'(countIN), 64'h00);
        cmp("t1_infoIN", 64'(infoIN), 64'h02);

        // 2: two-block packets, stalled and back-to-back
        send_pkt(8'h82, 8'd1, 64'h4444_3333_2222_1111, 2, 1'b0);
        cmp("t2_inDATA", 64'(inDATA), 64'h4444_3333);

        // 3: key packet with readDATA held high throughout
        send_pkt(8'h22, 8'd2, 64'h1918_1110_0908_0100, 0, 1'b1);
        cmp("t3_key", key, 64'h1918_1110_0908_0100);
        cmp("t3_countIN", 64'(countIN), 64'h02);

        // 4: header errors
        send_pkt(8'h02, 8'd5, 64'hdead_beef_0bad_f00d, 0, 1'b0);
        cmp("t4_infoIN_kept", 64'(infoIN), 64'h22);
        send_pkt(8'h82, 8'd3, 64'h0a0a_0b0b_0c0c_0d0d, 0, 1'b0);
        cmp("t4_inDATA", 64'(inDATA), 64'h0a0a_0b0b);
        send_pkt(8'h03, 8'd4, 64'h1, 0, 1'b0);
        send_pkt(8'h12, 8'd4, 64'h2, 1, 1'b0);
        cmp("t4_countIN_kept", 64'(countIN), 64'h03);

        // 5: 256 consecutive packets, sequence count wraps
        for (int i = 0; i < 256; i++) begin
            send_pkt((i % 5 == 0) ? 8'h22 : ((i % 3 == 0) ? 8'hC2 : 8'h42),
                     8'((4 + i) % 256), {16'(i * 7), 16'(i), 16'(~i), 16'(i * 3)},
                     i % 3, 1'(i % 2));
        end
        cmp("t5_countIN", 64'(countIN), 64'h03);

        // 6: reset while SEND0 is stalled
        in_bus  = {8'h02, 8'd4, 64'h0000_0000_abcd_1234};
        donePKT = 1'b1;
        step();
        step();
        e_done  = 1'b1;
        e_data  = 32'habcd_1234;
        e_info  = 8'h02;
        e_count = 8'd4;
        step();
        #1;
        nR = 1'b0;
        {e_done, e_rpkt, e_err, e_load} = '0;
        e_data = '0; e_key = '0; e_info = '0; e_count = '0;
        m_cnt = 8'd0;
        donePKT = 1'b0;
        #1;
        cmp("t6_doneDATA_rst", 64'(doneDATA), 64'h0);
        cmp("t6_readPKT_rst", 64'(readPKT), 64'h0);
        step();
        step();
        nR = 1'b1;
        step();
        send_pkt(8'h02, 8'd0, 64'h0000_0000_5555_aaaa, 1, 1'b0);
        cmp("t6_inDATA", 64'(inDATA), 64'h5555_aaaa);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
